// File: rtl/sisc_ifetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and imem (slave).
// Handshake: master raises imem_req with imem_addr and holds both stable until the
// cycle in which the slave raises imem_ack with valid imem_data; that cycle ends the read.
interface sisc_ifetch_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [DW-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/sisc_ifetch.sv
// SISC instruction-fetch stage: PC, IR, one imem read per fetch_en, with branch
// loads applied at fetch completion and a sticky timeout on a stalled memory.
module sisc_ifetch #(
   parameter int AW       = 16,
   parameter int DW       = 32,
   parameter int RESET_PC = 0,
   parameter int TIMEOUT  = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_en,
   input  logic          pc_write,
   input  logic [AW-1:0] br_addr,
   sisc_ifetch_if.master mem,
   output logic [DW-1:0] ir,
   output logic [3:0]    opcode,
   output logic [3:0]    mm,
   output logic [AW-1:0] pc_out,
   output logic          ir_valid,
   output logic          busy,
   output logic          fetch_err,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] ir_q;
   logic          ir_valid_q;
   logic          err_q;
   logic          pend_v_q;
   logic [AW-1:0] pend_q;
   logic [TW-1:0] tcnt_q;

   logic start, done, abort;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // An ack in REQ completes just like one in WAIT; ack beats timeout.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fetch_en) begin
               start   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ, S_WAIT: begin
            if (mem.imem_ack) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else if (tcnt_q == TMAX) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= AW'(RESET_PC);
         addr_q     <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_q     <= '0;
         tcnt_q     <= '0;
      end else begin
         ir_valid_q <= done | abort;
         if (state_q == S_IDLE) begin
            if (pc_write) pc_q <= br_addr;
            if (start)    addr_q <= pc_write ? br_addr : pc_q;
         end else if (done) begin
            ir_q     <= mem.imem_data;
            pc_q     <= pc_write ? br_addr : (pend_v_q ? pend_q : pc_q + AW'(1));
            pend_v_q <= 1'b0;
            tcnt_q   <= '0;
         end else if (abort) begin
            ir_q     <= '0;
            err_q    <= 1'b1;
            pend_v_q <= 1'b0;
            tcnt_q   <= '0;
         end else begin
            tcnt_q <= tcnt_q + TW'(1);
            // Latest branch target wins; PC itself moves only on completion.
            if (pc_write) begin
               pend_v_q <= 1'b1;
               pend_q   <= br_addr;
            end
         end
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign mem.imem_req  = busy;
   assign mem.imem_addr = addr_q;
   assign ir            = ir_q;
   assign opcode        = ir_q[DW-1 -: 4];
   assign mm            = ir_q[DW-5 -: 4];
   assign pc_out        = pc_q;
   assign ir_valid      = ir_valid_q;
   assign fetch_err     = err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_sisc_ifetch.sv
// Directed bench for sisc_ifetch: inputs driven and outputs sampled on the falling edge.
module tb_sisc_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_write;
  logic [15:0] br_addr;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc_out;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  sisc_ifetch_if #(.AW(16), .DW(32)) mem ();

  sisc_ifetch #(.AW(16), .DW(32), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .pc_write  (pc_write),
    .br_addr   (br_addr),
    .mem       (mem),
    .ir        (ir),
    .opcode    (opcode),
    .mm        (mm),
    .pc_out    (pc_out),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_err (fetch_err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nbusy;

    rst = 1'b1; fetch_en = 1'b0; pc_write = 1'b0; br_addr = '0;
    mem.imem_ack = 1'b0; mem.imem_data = '0;

    // 1. reset then minimum-latency fetch
    tick; tick;
    check("rst_pc", pc_out, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_req", mem.imem_req, 1'b0);
    check("rst_addr", mem.imem_addr, 32'h0);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    rst = 1'b0; fetch_en = 1'b1;
    tick; fetch_en = 1'b0;
    check("t1_req", mem.imem_req, 1'b1);
    check("t1_addr", mem.imem_addr, 32'h0);
    check("t1_state", state_dbg, 2'd1);
    mem.imem_ack = 1'b1; mem.imem_data = 32'hA1230010;
    tick; mem.imem_ack = 1'b0;
    check("t1_ir", ir, 32'hA1230010);
    check("t1_opcode", opcode, 4'hA);
    check("t1_mm", mm, 4'h1);
    check("t1_pc", pc_out, 32'h1);
    check("t1_valid", ir_valid, 1'b1);
    check("t1_req_drop", mem.imem_req, 1'b0);
    tick;
    check("t1_valid_once", ir_valid, 1'b0);

    // 2. ack after 5 waiting cycles, fetch_en pulses while busy ignored
    fetch_en = 1'b1;
    tick;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) nbusy++;
      check("t2_req", mem.imem_req, 1'b1);
      check("t2_addr", mem.imem_addr, 32'h1);
      check("t2_novalid", ir_valid, 1'b0);
      fetch_en = (i % 2 == 0);
      mem.imem_ack = (i == 5);
      mem.imem_data = 32'h5B000002;
      tick;
    end
    fetch_en = 1'b0; mem.imem_ack = 1'b0;
    check("t2_busy_cycles", nbusy, 6);
    check("t2_idle", busy, 1'b0);
    check("t2_ir", ir, 32'h5B000002);
    check("t2_pc", pc_out, 32'h2);
    check("t2_valid", ir_valid, 1'b1);
    tick;
    check("t2_no_refetch", busy, 1'b0);
    check("t2_valid_once", ir_valid, 1'b0);

    // 3. branch while idle, then branch together with fetch
    pc_write = 1'b1; br_addr = 16'h0040;
    tick; pc_write = 1'b0;
    check("t3_pc_load", pc_out, 32'h40);
    check("t3_idle", busy, 1'b0);
    pc_write = 1'b1; br_addr = 16'h0080; fetch_en = 1'b1;
    tick; pc_write = 1'b0; fetch_en = 1'b0;
    check("t3_addr", mem.imem_addr, 32'h80);
    mem.imem_ack = 1'b1; mem.imem_data = 32'h12340000;
    tick; mem.imem_ack = 1'b0;
    check("t3_pc", pc_out, 32'h81);
    check("t3_ir", ir, 32'h12340000);

    // 4. two branches while waiting, last one wins at completion
    pc_write = 1'b1; br_addr = 16'h0010;
    tick; pc_write = 1'b0; fetch_en = 1'b1;
    tick; fetch_en = 1'b0;
    tick;
    pc_write = 1'b1; br_addr = 16'h0200;
    tick;
    br_addr = 16'h0300;
    check("t4_pc_hold", pc_out, 32'h10);
    tick; pc_write = 1'b0;
    check("t4_pc_hold2", pc_out, 32'h10);
    mem.imem_ack = 1'b1; mem.imem_data = 32'hC0DE0010;
    tick; mem.imem_ack = 1'b0;
    check("t4_pc", pc_out, 32'h300);
    check("t4_ir", ir, 32'hC0DE0010);
    check("t4_addr", mem.imem_addr, 32'h10);

    // 5. PC wrap, then timeout with no ack
    pc_write = 1'b1; br_addr = 16'hFFFF;
    tick; pc_write = 1'b0; fetch_en = 1'b1;
    tick; fetch_en = 1'b0;
    check("t5_addr", mem.imem_addr, 32'hFFFF);
    mem.imem_ack = 1'b1; mem.imem_data = 32'h30000000;
    tick; mem.imem_ack = 1'b0;
    check("t5_wrap", pc_out, 32'h0);
    fetch_en = 1'b1;
    tick; fetch_en = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick;
    end
    check("t5_timeout_cycles", n, 15);
    check("t5_err", fetch_err, 1'b1);
    check("t5_ir_noop", ir, 32'h0);
    check("t5_pc", pc_out, 32'h0);
    check("t5_req", mem.imem_req, 1'b0);
    check("t5_valid", ir_valid, 1'b1);
    tick;
    fetch_en = 1'b1;
    tick; fetch_en = 1'b0;
    mem.imem_ack = 1'b1; mem.imem_data = 32'h70000000;
    tick; mem.imem_ack = 1'b0;
    check("t5_err_sticky", fetch_err, 1'b1);
    check("t5_pc_after", pc_out, 32'h1);

    // 6. reset mid-fetch, late ack ignored
    fetch_en = 1'b1;
    tick; fetch_en = 1'b0;
    tick;
    check("t6_waiting", state_dbg, 2'd2);
    rst = 1'b1;
    tick; rst = 1'b0;
    mem.imem_ack = 1'b1; mem.imem_data = 32'hFFFFFFFF;
    tick; mem.imem_ack = 1'b0;
    check("t6_pc", pc_out, 32'h0);
    check("t6_ir", ir, 32'h0);
    check("t6_valid", ir_valid, 1'b0);
    check("t6_req", mem.imem_req, 1'b0);
    check("t6_err_clr", fetch_err, 1'b0);
    tick;
    check("t6_valid_late", ir_valid, 1'b0);
    check("t6_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
